// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack card path.
// Ranks, card type, deck size, shoe FSM states, card point value.
package blackjack_pkg;

    typedef logic [3:0] card_t;
    typedef logic [2:0] state_t;

    localparam card_t RANK_ACE   = 4'd1;
    localparam card_t RANK_TEN   = 4'd10;
    localparam card_t RANK_JACK  = 4'd11;
    localparam card_t RANK_QUEEN = 4'd12;
    localparam card_t RANK_KING  = 4'd13;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_DRAW = 3'd1;
    localparam state_t S_SCAN = 3'd2;
    localparam state_t S_DONE = 3'd3;
    localparam state_t S_SHUF = 3'd4;

    function automatic logic [3:0] card_value(input card_t rank);
        if (rank >= RANK_JACK) begin
            return RANK_TEN;
        end
        return rank;
    endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// Free-running Galois LFSR used as the shoe's draw source.
// Ports: clk, reset (sync, active-high), q (current state).
module shoe_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    // An all-zero state would lock the register, so fall back.
    localparam logic [WIDTH-1:0] SEED_OK =
        (SEED == '0) ? WIDTH'(16'hACE1) : SEED;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[WIDTH-1:1]};
        if (q_q[0]) begin
            q_d = q_d ^ TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SEED_OK;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_shoe.sv
// Multi-deck shoe dealing 1..MAX_DEAL cards without replacement.
// In: deal_req/deal_num/shuffle_req. Out: deal_ready/valid/err, cards,
// cards_left, low_shoe, shoe_empty.
module card_shoe
    import blackjack_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter int          MAX_DEAL  = 2,
    parameter int          CUT_LEFT  = 13,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         TOTAL     = DECK_SIZE * NUM_DECKS,
    localparam int         NW        = $clog2(MAX_DEAL + 1),
    localparam int         CW        = $clog2(TOTAL + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  deal_req,
    input  logic [NW-1:0]         deal_num,
    input  logic                  shuffle_req,
    output logic                  deal_ready,
    output logic                  deal_valid,
    output logic                  deal_err,
    output logic [MAX_DEAL*4-1:0] cards,
    output logic [CW-1:0]         cards_left,
    output logic                  low_shoe,
    output logic                  shoe_empty
);

    localparam logic [5:0]    RANK_FULL = 6'(4 * NUM_DECKS);
    localparam logic [NW-1:0] MAX_N     = NW'(MAX_DEAL);
    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  err_q, err_d;
    logic [NW-1:0]         n_q, n_d;
    logic [NW-1:0]         slot_q, slot_d;
    card_t                 rank_q, rank_d;
    logic [CW-1:0]         r_q, r_d;
    logic [CW-1:0]         left_q, left_d;
    logic [5:0]            cnt_q [1:13];
    logic [5:0]            cnt_d [1:13];
    card_t                 wk_q [MAX_DEAL];
    card_t                 wk_d [MAX_DEAL];
    logic [MAX_DEAL*4-1:0] cards_q, cards_d;

    logic [15:0]   lfsr_q;
    logic [CW-1:0] left_m1;
    logic [CW-1:0] mask;
    logic [CW-1:0] r_draw;
    logic [5:0]    cnt_sel;
    logic          pick;
    logic          bad_req;
    logic          lfsr_unused;

    shoe_lfsr #(
        .WIDTH (16),
        .TAPS  (16'hB400),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:CW];

    // Smallest all-ones mask covering 0..cards_left-1.
    always_comb begin
        left_m1 = left_q - CW'(1);
        mask    = '0;
        for (int i = 0; i < CW; i++) begin
            mask[i] = |(left_m1 >> i);
        end
    end

    assign r_draw = lfsr_q[CW-1:0] & mask;

    always_comb begin
        cnt_sel = '0;
        for (int k = 1; k <= NUM_RANKS; k++) begin
            if (rank_q == card_t'(k)) begin
                cnt_sel = cnt_q[k];
            end
        end
    end

    assign pick    = r_q < CW'(cnt_sel);
    assign bad_req = (deal_num == '0) || (deal_num > MAX_N) ||
                     (CW'(deal_num) > left_q);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        n_d     = n_q;
        slot_d  = slot_q;
        rank_d  = rank_q;
        r_d     = r_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        wk_d    = wk_q;
        cards_d = cards_q;

        if (shuffle_req && state_q != S_IDLE && state_q != S_SHUF) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // A shuffle takes priority; a same-cycle deal is dropped.
                if (shuffle_req || pend_q) begin
                    state_d = S_SHUF;
                end else if (deal_req) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = deal_num;
                        slot_d  = '0;
                        state_d = S_DRAW;
                        for (int i = 0; i < MAX_DEAL; i++) begin
                            wk_d[i] = '0;
                        end
                    end
                end
            end
            S_DRAW: begin
                // Rejection sampling: retry until r lands below cards_left.
                if (r_draw < left_q) begin
                    r_d     = r_draw;
                    rank_d  = RANK_ACE;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (pick) begin
                    left_d = left_q - CW'(1);
                    slot_d = slot_q + NW'(1);
                    for (int k = 1; k <= NUM_RANKS; k++) begin
                        if (rank_q == card_t'(k)) begin
                            cnt_d[k] = cnt_q[k] - 6'd1;
                        end
                    end
                    for (int i = 0; i < MAX_DEAL; i++) begin
                        if (NW'(i) == slot_q) begin
                            wk_d[i] = rank_q;
                        end
                    end
                    if (slot_d == n_q) begin
                        state_d = S_DONE;
                        for (int i = 0; i < MAX_DEAL; i++) begin
                            cards_d[4*i +: 4] =
                                (NW'(i) == slot_q) ? rank_q : wk_q[i];
                        end
                    end else begin
                        state_d = S_DRAW;
                    end
                end else begin
                    r_d    = r_q - CW'(cnt_sel);
                    rank_d = rank_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = (pend_q || shuffle_req) ? S_SHUF : S_IDLE;
            end
            S_SHUF: begin
                for (int k = 1; k <= NUM_RANKS; k++) begin
                    cnt_d[k] = RANK_FULL;
                end
                left_d  = TOTAL_C;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= '0;
            slot_q  <= '0;
            rank_q  <= RANK_ACE;
            r_q     <= '0;
            left_q  <= TOTAL_C;
            cards_q <= '0;
            for (int k = 1; k <= NUM_RANKS; k++) begin
                cnt_q[k] <= RANK_FULL;
            end
            for (int i = 0; i < MAX_DEAL; i++) begin
                wk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            n_q     <= n_d;
            slot_q  <= slot_d;
            rank_q  <= rank_d;
            r_q     <= r_d;
            left_q  <= left_d;
            cards_q <= cards_d;
            cnt_q   <= cnt_d;
            wk_q    <= wk_d;
        end
    end

    // A valid residual must be exhausted by the last rank.
    king_picks: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_SCAN && rank_q == RANK_KING) |-> pick);

    assign deal_ready = (state_q == S_IDLE) && !pend_q;
    assign deal_valid = (state_q == S_DONE);
    assign deal_err   = err_q;
    assign cards      = cards_q;
    assign cards_left = left_q;
    assign low_shoe   = 32'(left_q) < CUT_LEFT;
    assign shoe_empty = (left_q == '0);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: 1-deck and 2-deck instances.
// Checks dealing, drain counts, errors, shuffles and reset.
module tb_card_shoe;
    import blackjack_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, deal_req, shuffle_req;
    logic [1:0] deal_num;
    logic       deal_ready, deal_valid, deal_err;
    logic [7:0] cards;
    logic [5:0] cards_left;
    logic       low_shoe, shoe_empty;

    logic       reset2, deal_req2, shuffle_req2;
    logic [1:0] deal_num2;
    logic       deal_ready2, deal_valid2, deal_err2;
    logic [7:0] cards2;
    logic [6:0] cards_left2;
    logic       low_shoe2, shoe_empty2;

    card_shoe #(.NUM_DECKS(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .deal_req    (deal_req),
        .deal_num    (deal_num),
        .shuffle_req (shuffle_req),
        .deal_ready  (deal_ready),
        .deal_valid  (deal_valid),
        .deal_err    (deal_err),
        .cards       (cards),
        .cards_left  (cards_left),
        .low_shoe    (low_shoe),
        .shoe_empty  (shoe_empty)
    );

    card_shoe #(.NUM_DECKS(2)) dut2 (
        .clk         (clk),
        .reset       (reset2),
        .deal_req    (deal_req2),
        .deal_num    (deal_num2),
        .shuffle_req (shuffle_req2),
        .deal_ready  (deal_ready2),
        .deal_valid  (deal_valid2),
        .deal_err    (deal_err2),
        .cards       (cards2),
        .cards_left  (cards_left2),
        .low_shoe    (low_shoe2),
        .shoe_empty  (shoe_empty2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int in_range(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd13) ? 1 : 0;
    endfunction

    task automatic deal1(input int n, input int budget,
                         output int nv, output int ne,
                         output logic [7:0] c);
        int tail;
        nv = 0; ne = 0; c = '0; tail = -1;
        @(negedge clk); deal_req = 1'b1; deal_num = 2'(n);
        @(negedge clk); deal_req = 1'b0; deal_num = '0;
        for (int i = 0; i < budget; i++) begin
            if (deal_valid) begin nv++; c = cards; end
            if (deal_err) ne++;
            if (tail < 0 && (nv > 0 || ne > 0)) tail = 2;
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk);
        end
    endtask

    task automatic deal2(input int n, input int budget,
                         output int nv, output int ne,
                         output logic [7:0] c);
        int tail;
        nv = 0; ne = 0; c = '0; tail = -1;
        @(negedge clk); deal_req2 = 1'b1; deal_num2 = 2'(n);
        @(negedge clk); deal_req2 = 1'b0; deal_num2 = '0;
        for (int i = 0; i < budget; i++) begin
            if (deal_valid2) begin nv++; c = cards2; end
            if (deal_err2) ne++;
            if (tail < 0 && (nv > 0 || ne > 0)) tail = 2;
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk);
        end
    endtask

    int nv, ne, found, bad_deal, bad_rank, bad_slot, bad_left, bad_low;
    int tally [14];
    logic [7:0] c;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; deal_req = 1'b0; deal_num = '0; shuffle_req = 1'b0;
        reset2 = 1'b1; deal_req2 = 1'b0; deal_num2 = '0; shuffle_req2 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_left", int'(cards_left), 52);
        check("rst_ready", int'(deal_ready), 1);
        check("rst_valid", int'(deal_valid), 0);
        check("rst_err", int'(deal_err), 0);
        check("rst_low", int'(low_shoe), 0);
        check("rst_empty", int'(shoe_empty), 0);
        check("rst_cards", int'(cards), 0);

        deal1(2, 60, nv, ne, c);
        check("d2_valid", nv, 1);
        check("d2_err", ne, 0);
        check("d2_slot0", in_range(c[3:0]), 1);
        check("d2_slot1", in_range(c[7:4]), 1);
        check("d2_left", int'(cards_left), 50);
        check("d2_ready", int'(deal_ready), 1);

        @(negedge clk); deal_req = 1'b1; deal_num = 2'd1; shuffle_req = 1'b1;
        @(negedge clk); deal_req = 1'b0; deal_num = '0; shuffle_req = 1'b0;
        nv = 0; ne = 0;
        for (int i = 0; i < 40; i++) begin
            if (deal_valid) nv++;
            if (deal_err) ne++;
            @(negedge clk);
        end
        check("same_cyc_valid", nv, 0);
        check("same_cyc_err", ne, 0);
        check("same_cyc_left", int'(cards_left), 52);
        check("same_cyc_ready", int'(deal_ready), 1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 14; r++) tally[r] = 0;
        bad_deal = 0; bad_rank = 0; bad_slot = 0; bad_left = 0; bad_low = 0;
        for (int k = 0; k < 51; k++) begin
            deal1(1, 400, nv, ne, c);
            if (nv != 1 || ne != 0) bad_deal++;
            if (in_range(c[3:0]) == 1) tally[c[3:0]]++;
            else bad_rank++;
            if (c[7:4] != 4'd0) bad_slot++;
            if (int'(cards_left) != 51 - k) bad_left++;
            if (int'(low_shoe) != ((51 - k < 13) ? 1 : 0)) bad_low++;
        end
        check("drain_left1", int'(cards_left), 1);
        check("drain_low1", int'(low_shoe), 1);
        check("drain_empty1", int'(shoe_empty), 0);

        deal1(2, 60, nv, ne, c);
        check("over_err", ne, 1);
        check("over_valid", nv, 0);
        check("over_left", int'(cards_left), 1);
        deal1(0, 60, nv, ne, c);
        check("zero_err", ne, 1);
        check("zero_valid", nv, 0);
        deal1(3, 60, nv, ne, c);
        check("max_err", ne, 1);

        deal1(1, 400, nv, ne, c);
        if (nv != 1 || ne != 0) bad_deal++;
        if (in_range(c[3:0]) == 1) tally[c[3:0]]++;
        else bad_rank++;
        check("last_left", int'(cards_left), 0);
        check("last_empty", int'(shoe_empty), 1);
        check("last_low", int'(low_shoe), 1);
        check("drain_bad_deal", bad_deal, 0);
        check("drain_bad_rank", bad_rank, 0);
        check("drain_bad_slot", bad_slot, 0);
        check("drain_bad_left", bad_left, 0);
        check("drain_bad_low", bad_low, 0);
        for (int r = 1; r <= 13; r++) begin
            check($sformatf("tally1_r%0d", r), tally[r], 4);
        end
        deal1(1, 60, nv, ne, c);
        check("empty_err", ne, 1);

        @(negedge clk); shuffle_req = 1'b1;
        @(negedge clk); shuffle_req = 1'b0;
        check("shuf_busy", int'(deal_ready), 0);
        @(negedge clk);
        check("shuf_left", int'(cards_left), 52);
        check("shuf_ready", int'(deal_ready), 1);

        @(negedge clk); deal_req = 1'b1; deal_num = 2'd2;
        @(negedge clk); deal_req = 1'b0; deal_num = '0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (dut.state_q == S_SCAN) begin found = 1; break; end
            @(negedge clk);
        end
        check("t5_scan_seen", found, 1);
        shuffle_req = 1'b1;
        @(negedge clk); shuffle_req = 1'b0;
        check("t5_ready_busy", int'(deal_ready), 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (deal_valid) begin found = 1; break; end
            @(negedge clk);
        end
        check("t5_valid", found, 1);
        check("t5_left_at_valid", int'(cards_left), 50);
        check("t5_slots", in_range(cards[3:0]) + in_range(cards[7:4]), 2);
        @(negedge clk);
        check("t5_shuf_ready", int'(deal_ready), 0);
        check("t5_shuf_valid", int'(deal_valid), 0);
        @(negedge clk);
        check("t5_left", int'(cards_left), 52);
        check("t5_ready", int'(deal_ready), 1);

        reset2 = 1'b0;
        @(negedge clk);
        check("d2rst_left", int'(cards_left2), 104);
        check("d2rst_ready", int'(deal_ready2), 1);
        check("d2rst_empty", int'(shoe_empty2), 0);
        for (int r = 0; r < 14; r++) tally[r] = 0;
        bad_deal = 0; bad_rank = 0;
        for (int k = 0; k < 104; k++) begin
            deal2(1, 400, nv, ne, c);
            if (nv != 1 || ne != 0) bad_deal++;
            if (in_range(c[3:0]) == 1) tally[c[3:0]]++;
            else bad_rank++;
        end
        check("d2_bad_deal", bad_deal, 0);
        check("d2_bad_rank", bad_rank, 0);
        check("d2_empty", int'(shoe_empty2), 1);
        for (int r = 1; r <= 13; r++) begin
            check($sformatf("tally2_r%0d", r), tally[r], 8);
        end

        reset2 = 1'b1;
        @(negedge clk); reset2 = 1'b0;
        @(negedge clk); deal_req2 = 1'b1; deal_num2 = 2'd2;
        @(negedge clk); deal_req2 = 1'b0; deal_num2 = '0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (dut2.state_q == S_SCAN) begin found = 1; break; end
            @(negedge clk);
        end
        check("rmid_scan_seen", found, 1);
        reset2 = 1'b1;
        @(negedge clk); reset2 = 1'b0;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (deal_valid2) nv++;
            @(negedge clk);
        end
        check("rmid_valid", nv, 0);
        check("rmid_left", int'(cards_left2), 104);
        check("rmid_cards", int'(cards2), 0);
        check("rmid_ready", int'(deal_ready2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
